// File: rtl/lf_pkg.sv
// Shared types and default widths for the line fill engine.
package lf_pkg;

    localparam int unsigned LF_ADDR_W = 28;
    localparam int unsigned LF_LINE_W = 128;
    localparam int unsigned LF_STAT_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB   = 3'd1,
        GAP  = 3'd2,
        FILL = 3'd3,
        DONE = 3'd4
    } lf_state_e;

endpackage

// File: rtl/lf_timeout_cnt.sv
// Per-transfer wait counter; term_c flags the cycle whose increment reaches LIMIT.
// LIMIT=0 disables the terminal flag.
module lf_timeout_cnt #(
    parameter int unsigned CNT_W = 10,
    parameter int unsigned LIMIT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term_c
);

    localparam int unsigned LIMIT_M1 = (LIMIT == 0) ? 0 : LIMIT - 1;

    logic [CNT_W-1:0] cnt;

    // Clear has priority so a state change always starts the next transfer at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign term_c = (LIMIT != 0) && en && (cnt == CNT_W'(LIMIT_M1));

endmodule

// File: rtl/line_fill_engine.sv
// Cache miss initiator: optional victim write-back, then a line read from slow memory.
// Optional counters: define LINE_FILL_STATS_EN to add stat_miss/stat_wb/stat_stall.
module line_fill_engine
    import lf_pkg::*;
#(
    parameter int unsigned ADDR_W  = LF_ADDR_W,
    parameter int unsigned LINE_W  = LF_LINE_W,
    parameter int unsigned TIMEOUT = 1023,
    parameter int unsigned TO_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wb,
    input  logic [ADDR_W-1:0] req_victim_addr,
    input  logic [LINE_W-1:0] req_victim_data,
    input  logic [ADDR_W-1:0] req_fill_addr,
    output logic              busy,
    output logic              fill_done,
    output logic [LINE_W-1:0] fill_data,
    output logic              timeout_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef LINE_FILL_STATS_EN
    ,
    output logic [LF_STAT_W-1:0] stat_miss,
    output logic [LF_STAT_W-1:0] stat_wb,
    output logic [LF_STAT_W-1:0] stat_stall
`endif
);

    lf_state_e         state, state_d;
    logic              busy_d, fill_done_d, timeout_err_d;
    logic              mem_read_d, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_d, fill_addr_q, fill_addr_d;
    logic [LINE_W-1:0] fill_data_d, mem_wdata_d;
    logic              to_en, to_clr, to_term_c;

    assign to_en  = ((state == WB) || (state == FILL)) && !mem_ready;
    assign to_clr = (state_d != state);

    lf_timeout_cnt #(
        .CNT_W (TO_W),
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (to_clr),
        .en     (to_en),
        .term_c (to_term_c)
    );

    // Next state and next value of every registered output.
    always_comb begin
        state_d       = state;
        busy_d        = busy;
        fill_done_d   = 1'b0;
        fill_data_d   = fill_data;
        timeout_err_d = timeout_err;
        mem_read_d    = mem_read;
        mem_write_d   = mem_write;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        fill_addr_d   = fill_addr_q;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    busy_d      = 1'b1;
                    fill_addr_d = req_fill_addr;
                    if (req_wb) begin
                        state_d     = WB;
                        mem_write_d = 1'b1;
                        mem_addr_d  = req_victim_addr;
                        mem_wdata_d = req_victim_data;
                    end else begin
                        state_d    = FILL;
                        mem_read_d = 1'b1;
                        mem_addr_d = req_fill_addr;
                    end
                end
            end
            WB: begin
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    state_d     = GAP;
                end else if (to_term_c) begin
                    mem_write_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    fill_done_d   = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = DONE;
                end
            end
            GAP: begin
                state_d    = FILL;
                mem_read_d = 1'b1;
                mem_addr_d = fill_addr_q;
            end
            FILL: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    fill_data_d = mem_rdata;
                    fill_done_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end else if (to_term_c) begin
                    mem_read_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    fill_done_d   = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            fill_done   <= 1'b0;
            fill_data   <= '0;
            timeout_err <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            fill_addr_q <= '0;
        end else begin
            state       <= state_d;
            busy        <= busy_d;
            fill_done   <= fill_done_d;
            fill_data   <= fill_data_d;
            timeout_err <= timeout_err_d;
            mem_read    <= mem_read_d;
            mem_write   <= mem_write_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            fill_addr_q <= fill_addr_d;
        end
    end

`ifdef LINE_FILL_STATS_EN
    // Saturating usage counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_miss  <= '0;
            stat_wb    <= '0;
            stat_stall <= '0;
        end else begin
            if ((state == IDLE) && req_valid && (stat_miss != '1)) begin
                stat_miss <= stat_miss + LF_STAT_W'(1);
            end
            if ((state == IDLE) && req_valid && req_wb && (stat_wb != '1)) begin
                stat_wb <= stat_wb + LF_STAT_W'(1);
            end
            if (busy && (stat_stall != '1)) begin
                stat_stall <= stat_stall + LF_STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_fill_engine.sv
// Directed bench for line_fill_engine with a fixed-latency slow-memory model.
module tb_line_fill_engine;

    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_wb;
    logic [27:0]   req_victim_addr;
    logic [127:0]  req_victim_data;
    logic [27:0]   req_fill_addr;
    logic          busy;
    logic          fill_done;
    logic [127:0]  fill_data;
    logic          timeout_err;
    logic          mem_read;
    logic          mem_write;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;
`ifdef LINE_FILL_STATS_EN
    logic [15:0]   stat_miss;
    logic [15:0]   stat_wb;
    logic [15:0]   stat_stall;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    logic          mem_off;
    int            lat_cnt;
    logic [127:0]  wb_mem [0:63];

    logic [27:0]   exp_va;
    logic [127:0]  exp_vd;
    logic [27:0]   exp_fa;
    int            rd_n, wr_n, gap_n, cyc, addr_bad;
    logic          done_ok;

    line_fill_engine #(
        .ADDR_W  (28),
        .LINE_W  (128),
        .TIMEOUT (8),
        .TO_W    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_wb          (req_wb),
        .req_victim_addr (req_victim_addr),
        .req_victim_data (req_victim_data),
        .req_fill_addr   (req_fill_addr),
        .busy            (busy),
        .fill_done       (fill_done),
        .fill_data       (fill_data),
        .timeout_err     (timeout_err),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ready       (mem_ready)
`ifdef LINE_FILL_STATS_EN
        ,
        .stat_miss       (stat_miss),
        .stat_wb         (stat_wb),
        .stat_stall      (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] line_of(input logic [27:0] a);
        return {4{4'hC, a}};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory: ready pulses for one cycle once a request has been up LAT cycles.
    always @(posedge clk) begin
        if (rst) begin
            mem_ready <= 1'b0;
            lat_cnt   <= 0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= 1'b0;
            if (!(mem_read || mem_write) || mem_off) begin
                lat_cnt <= 0;
            end else if (!mem_ready) begin
                if (lat_cnt == LAT - 2) begin
                    mem_ready <= 1'b1;
                    lat_cnt   <= 0;
                    if (mem_write) wb_mem[mem_addr[5:0]] <= mem_wdata;
                    else           mem_rdata <= line_of(mem_addr);
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) check("rw_excl", 128'(mem_read & mem_write), 128'(0));
    end

    task automatic issue(input logic wb, input logic [27:0] va, input logic [127:0] vd,
                         input logic [27:0] fa);
        req_valid       = 1'b1;
        req_wb          = wb;
        req_victim_addr = va;
        req_victim_data = vd;
        req_fill_addr   = fa;
        exp_va = va;
        exp_vd = vd;
        exp_fa = fa;
    endtask

    // Step to fill_done, tallying request cycles; scrambles request fields unless hold.
    task automatic wait_done(input bit hold, input int budget);
        rd_n = 0; wr_n = 0; gap_n = 0; cyc = 0; addr_bad = 0; done_ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            cyc++;
            if (!hold) begin
                req_valid       = 1'b0;
                req_wb          = ~exp_va[0];
                req_fill_addr   = 28'h000003F;
                req_victim_addr = 28'h000003E;
                req_victim_data = '0;
            end
            if (fill_done) begin
                done_ok = 1'b1;
                break;
            end
            if (mem_read) begin
                rd_n++;
                if (mem_addr !== exp_fa) addr_bad++;
            end
            if (mem_write) begin
                wr_n++;
                if (mem_addr !== exp_va || mem_wdata !== exp_vd) addr_bad++;
            end
            if (!mem_read && !mem_write && wr_n > 0 && rd_n == 0) gap_n++;
        end
    endtask

    initial begin
        logic [127:0] a5;
        int done_seen;
        a5 = {16{8'hA5}};
        rst = 1'b1;
        mem_off = 1'b0;
        req_valid = 1'b0; req_wb = 1'b0;
        req_victim_addr = '0; req_victim_data = '0; req_fill_addr = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_busy",   128'(busy), 128'(0));
        check("rst_done",   128'(fill_done), 128'(0));
        check("rst_fdata",  fill_data, 128'(0));
        check("rst_err",    128'(timeout_err), 128'(0));
        check("rst_rd",     128'(mem_read), 128'(0));
        check("rst_wr",     128'(mem_write), 128'(0));
        check("rst_addr",   128'(mem_addr), 128'(0));
        check("rst_wdata",  mem_wdata, 128'(0));

        // Clean fill
        issue(1'b0, 28'h0, '0, 28'h0000010);
        wait_done(1'b0, 40);
        check("clean_done",  128'(done_ok), 128'(1));
        check("clean_lat",   128'(cyc), 128'(5));
        check("clean_rd",    128'(rd_n), 128'(4));
        check("clean_wr",    128'(wr_n), 128'(0));
        check("clean_addr",  128'(addr_bad), 128'(0));
        check("clean_data",  fill_data, line_of(28'h0000010));
        check("clean_busy",  128'(busy), 128'(0));
        @(negedge clk);
        check("clean_pulse", 128'(fill_done), 128'(0));

        // Dirty miss
        issue(1'b1, 28'h0000020, a5, 28'h0000030);
        wait_done(1'b0, 60);
        check("dirty_done",  128'(done_ok), 128'(1));
        check("dirty_lat",   128'(cyc), 128'(10));
        check("dirty_wr",    128'(wr_n), 128'(4));
        check("dirty_gap",   128'(gap_n), 128'(1));
        check("dirty_rd",    128'(rd_n), 128'(4));
        check("dirty_addr",  128'(addr_bad), 128'(0));
        check("dirty_data",  fill_data, line_of(28'h0000030));
        check("dirty_mem",   wb_mem[32], a5);

        // Back-to-back with req_valid held
        @(negedge clk);
        issue(1'b0, 28'h0, '0, 28'h0000010);
        wait_done(1'b1, 40);
        check("b2b1_done", 128'(done_ok), 128'(1));
        check("b2b1_lat",  128'(cyc), 128'(5));
        check("b2b1_data", fill_data, line_of(28'h0000010));
        req_fill_addr = 28'h0000030;
        exp_fa = 28'h0000030;
        @(negedge clk);
        check("b2b_idle_busy", 128'(busy), 128'(0));
        check("b2b_idle_rd",   128'(mem_read), 128'(0));
        wait_done(1'b0, 40);
        check("b2b2_done", 128'(done_ok), 128'(1));
        check("b2b2_lat",  128'(cyc), 128'(5));
        check("b2b2_rd",   128'(rd_n), 128'(4));
        check("b2b2_data", fill_data, line_of(28'h0000030));

        // Timeout on a silent memory
        @(negedge clk);
        mem_off = 1'b1;
        issue(1'b0, 28'h0, '0, 28'h0000010);
        wait_done(1'b0, 40);
        check("to_done", 128'(done_ok), 128'(1));
        check("to_lat",  128'(cyc), 128'(9));
        check("to_rd",   128'(rd_n), 128'(8));
        check("to_err",  128'(timeout_err), 128'(1));
        check("to_data", fill_data, line_of(28'h0000030));
        check("to_busy", 128'(busy), 128'(0));
        @(negedge clk);
        mem_off = 1'b0;
        check("to_sticky", 128'(timeout_err), 128'(1));

        // Reset during write-back
        issue(1'b1, 28'h0000020, ~a5, 28'h0000030);
        @(negedge clk);
        req_valid = 1'b0;
        check("rstwb_wr_pre", 128'(mem_write), 128'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstwb_wr",   128'(mem_write), 128'(0));
        check("rstwb_busy", 128'(busy), 128'(0));
        check("rstwb_err",  128'(timeout_err), 128'(0));
        done_seen = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (fill_done) done_seen++;
        end
        check("rstwb_no_done", 128'(done_seen), 128'(0));
        check("rstwb_mem",     wb_mem[32], a5);

`ifdef LINE_FILL_STATS_EN
        check("st_rst_miss", 128'(stat_miss), 128'(0));
        issue(1'b0, 28'h0, '0, 28'h0000010);
        wait_done(1'b0, 40);
        @(negedge clk);
        issue(1'b1, 28'h0000020, a5, 28'h0000030);
        wait_done(1'b0, 60);
        @(negedge clk);
        issue(1'b0, 28'h0, '0, 28'h0000030);
        wait_done(1'b0, 40);
        @(negedge clk);
        check("st_miss",  128'(stat_miss), 128'(3));
        check("st_wb",    128'(stat_wb), 128'(1));
        check("st_stall", 128'(stat_stall), 128'(17));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/line_fill_engine.md
Name: line_fill_engine

Overview:
- Cache-side initiator for the slow-memory line interface: the mem_read/mem_write/mem_addr[31:4]/mem_wdata/mem_rdata/mem_ready port of the D- and I-caches.
- Takes one miss request from the cache controller. If the victim line is dirty, it first writes the victim back, then reads the missing 128-bit line and returns it to the cache.
- One instance per cache inside CHIP; it is the requesting end of the slow_memory protocol.

Parameters:
- ADDR_W, 28, line address width (byte address bits [31:4]).
- LINE_W, 128, line width in bits.
- TIMEOUT, 1023, maximum cycles to wait for mem_ready per transfer; 0 disables the timeout.
- TO_W, 10, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  miss request; sampled only when busy=0.
- req_wb  in  1  victim dirty, so a write-back is required.
- req_victim_addr  in  ADDR_W  victim line address.
- req_victim_data  in  LINE_W  victim line data.
- req_fill_addr  in  ADDR_W  line address to fetch.
- busy  out  1  engine occupied.
- fill_done  out  1  one-cycle pulse; fill_data valid in that cycle.
- fill_data  out  LINE_W  fetched line, held until the next capture.
- timeout_err  out  1  sticky; cleared only by reset.
- mem_read  out  1  read request to memory.
- mem_write  out  1  write request to memory.
- mem_addr  out  ADDR_W  line address to memory.
- mem_wdata  out  LINE_W  write data to memory.
- mem_rdata  in  LINE_W  read data, valid while mem_ready=1.
- mem_ready  in  1  memory completion, one or more cycles high.

Behaviour:
- All outputs are registered.
- Reset state: every output 0, FSM in IDLE, timeout counter 0. An asserted rst aborts any transfer immediately, with no completion pulse.
- FSM states: IDLE, WB, GAP, FILL, DONE.
- IDLE:
  - If req_valid=1, latch all request fields and set busy=1.
  - Go to WB if req_wb=1, otherwise go to FILL.
  - mem_read/mem_write assert in the first cycle of the new state.
- WB: mem_write=1, mem_addr=victim address, mem_wdata=victim data, all held stable. On the edge that samples mem_ready=1, deassert mem_write and go to GAP.
- GAP: exactly one cycle with mem_read=mem_write=0, so the memory sees the request drop. Then go to FILL.
- FILL: mem_read=1, mem_addr=fill address. On the edge that samples mem_ready=1, capture mem_rdata into fill_data, deassert mem_read and go to DONE.
- DONE: fill_done=1 for one cycle, busy=0 in the same cycle, then go to IDLE.
- A new request can be accepted in the cycle after DONE. Minimum miss latency without write-back, request to fill_done: 1 cycle + memory latency + 1 cycle.
- mem_read and mem_write are never high together. Neither is re-asserted in the cycle after mem_ready is sampled.
- mem_ready sampled while in IDLE, GAP or DONE is ignored.
- Timeout (TIMEOUT>0):
  - The counter increments each cycle in WB or FILL while mem_ready=0, and clears on every state change.
  - When the counter reaches TIMEOUT, set timeout_err=1, drop the request, and go to DONE. fill_done pulses and fill_data keeps its old value.
- req_valid while busy=1 is ignored; the cache must hold its request.
- Request fields change freely after acceptance; only the latched copies are used.

Optional Feature:
- Macro: LINE_FILL_STATS_EN.
- Defined: adds three 16-bit saturating outputs, each cleared by reset:
  - stat_miss: increments on each accepted request.
  - stat_wb: increments on each accepted request with req_wb=1.
  - stat_stall: increments on each cycle busy=1.
- Not defined: these ports and registers do not exist. Core behaviour is identical either way.

Decomposition:
- Shared package lf_pkg: state enum (IDLE, WB, GAP, FILL, DONE), default widths ADDR_W=28 and LINE_W=128, and the stat counter width of 16.
- Sub-module lf_timeout_cnt: counter with clear, enable and a terminal flag. Instantiated once.
- Everything else stays in line_fill_engine.

Test Plan:
- Clean fill, memory latency 4:
  - Stimulus: req_wb=0, fill_addr=28'h0000010.
  - Required: mem_read high for exactly 4 cycles with mem_addr=28'h0000010; fill_done one cycle later; fill_data equals the memory line.
- Dirty miss:
  - Stimulus: req_wb=1, victim_addr=28'h0000020, victim_data=128'hA5...A5, fill_addr=28'h0000030.
  - Required: write completes first, then exactly one cycle with both requests low, then the read. Memory location 0x020 holds A5...A5.
- Back-to-back:
  - Stimulus: req_valid held high across two misses.
  - Required: the second request is accepted exactly one cycle after the first fill_done. mem_read and mem_write are never high together (checked every cycle).
- Timeout:
  - Stimulus: TIMEOUT=8, mem_ready tied 0.
  - Required: mem_read drops after 8 cycles; timeout_err=1; fill_done pulses; fill_data unchanged.
- Reset mid-write-back:
  - Stimulus: assert rst during WB.
  - Required: mem_write=0, busy=0, timeout_err=0 asynchronously, with no fill_done pulse.
- Stats (LINE_FILL_STATS_EN defined):
  - Stimulus: 3 misses, 1 of them dirty.
  - Required: stat_miss=3, stat_wb=1, stat_stall equals the total count of busy cycles.
